keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_debounce.sv | 66 ++++++
 rtl/keypad_entry_ctrl.sv | 115 +++++++++++
 tb/tb_keypad_entry_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and digit classification for the keypad entry block.
// Define KEYPAD_HEX_ENTRY_EN to accept codes 4'hA-4'hD as digits.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccum   = 2'd1,
    StWaitAck = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
`ifdef KEYPAD_HEX_ENTRY_EN
    return code <= 4'hD;
`else
    return code <= 4'h9;
`endif
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces the scanner's {pressed, code} pair and emits a one-cycle press pulse on an
// accepted 0->1 transition of the pressed level.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] key_code_i,
  input  logic       key_pressed_i,
  output logic       press_o,
  output logic [3:0] press_code_o
);

  localparam int unsigned Target = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(Target + 1);

  logic [4:0]      sample;
  logic [4:0]      cand_q, cand_d;
  logic [4:0]      stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic [3:0]      code_q, code_d;

  assign sample = {key_pressed_i, key_code_i};

  // cnt counts consecutive identical samples including the current one, saturating at Target.
  always_comb begin
    cand_d   = sample;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    code_d   = code_q;
    if (sample != cand_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntW'(Target)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (cnt_d == CntW'(Target) && sample != stable_q) begin
      stable_d = sample;
      press_d  = sample[4] & ~stable_q[4];
      code_d   = sample[3:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      press_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      code_q   <= code_d;
    end
  end

  assign press_o      = press_q;
  assign press_code_o = code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad digit accumulator with clear/enter keys and a valid/ready entry handshake.
// Hex digits A-D are accepted only when KEYPAD_HEX_ENTRY_EN is defined.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned N_DIGITS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [3:0]                       key_code,
  input  logic                             key_pressed,
  output logic [4*N_DIGITS-1:0]            entry_value,
  output logic                             entry_valid,
  input  logic                             entry_ready,
  output logic [4*N_DIGITS-1:0]            display_value,
  output logic [$clog2(N_DIGITS+1)-1:0]    digit_count,
  output logic                             overflow
);

  localparam int unsigned AccW = 4 * N_DIGITS;
  localparam int unsigned CntW = $clog2(N_DIGITS + 1);

  logic       press;
  logic [3:0] press_code;

  entry_state_e    state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] entry_q, entry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_code_i   (key_code),
    .key_pressed_i(key_pressed),
    .press_o      (press),
    .press_code_o (press_code)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (press) begin
          if (press_code == KEY_CLEAR) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = StIdle;
          end else if (press_code == KEY_ENTER) begin
            if (state_q == StAccum) begin
              entry_d = acc_q;
              valid_d = 1'b1;
              state_d = StWaitAck;
            end
          end else if (is_digit(press_code)) begin
            if (cnt_q < CntW'(N_DIGITS)) begin
              acc_d   = (acc_q << 4) | AccW'(press_code);
              cnt_d   = cnt_q + CntW'(1);
              state_d = StAccum;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      // Presses here are dropped, including one landing on the handshake cycle.
      StWaitAck: begin
        if (valid_q && entry_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      entry_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign entry_value   = entry_q;
  assign entry_valid   = valid_q;
  assign display_value = acc_q;
  assign digit_count   = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized bench for keypad_entry_ctrl against a key-level behavioural model.
module tb_keypad_entry_ctrl;

  localparam int unsigned NDig      = 4;
  localparam int unsigned Deb       = 8;
  localparam int unsigned RelCycles = Deb + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [15:0] entry_value;
  logic        entry_valid;
  logic        entry_ready;
  logic [15:0] display_value;
  logic [2:0]  digit_count;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .N_DIGITS       (NDig),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .entry_value  (entry_value),
    .entry_valid  (entry_valid),
    .entry_ready  (entry_ready),
    .display_value(display_value),
    .digit_count  (digit_count),
    .overflow     (overflow)
  );

  // Reference model: entry contents as a number, digit count, sticky overflow, pending entry.
  int unsigned m_acc, m_cnt, m_pend;
  bit          m_ovf, m_wait;
  int unsigned exp_q[$];
  int unsigned got_q[$];

  int          valid_run = 0;
  int          last_run  = 0;
  int          unstable  = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_value = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_dig(input logic [3:0] c);
`ifdef KEYPAD_HEX_ENTRY_EN
    return c <= 4'hD;
`else
    return c <= 4'h9;
`endif
  endfunction

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_press(input logic [3:0] c, input bit rdy);
    if (m_wait) return;
    if (c == 4'hE) begin
      model_clear();
    end else if (c == 4'hF) begin
      if (m_cnt > 0) begin
        if (rdy) begin
          exp_q.push_back(m_acc);
          model_clear();
        end else begin
          m_pend = m_acc;
          m_wait = 1;
        end
      end
    end else if (is_dig(c)) begin
      if (m_cnt < NDig) begin
        m_acc = (m_acc * 16 + c) % 65536;
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  // Handshake log and stability watch on entry_value while valid is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_run  = 0;
      prev_valid = 1'b0;
    end else begin
      if (entry_valid && entry_ready) got_q.push_back(entry_value);
      if (entry_valid && prev_valid && entry_value != prev_value) unstable++;
      if (entry_valid) begin
        valid_run++;
      end else if (valid_run > 0) begin
        last_run  = valid_run;
        valid_run = 0;
      end
      prev_valid = entry_valid;
      prev_value = entry_value;
    end
  end

  task automatic compare_state(input string tag);
    check({tag, "/display"}, display_value, m_acc);
    check({tag, "/count"}, digit_count, m_cnt);
    check({tag, "/overflow"}, overflow, m_ovf);
    check({tag, "/valid"}, entry_valid, m_wait);
    if (m_wait) check({tag, "/held_value"}, entry_value, m_pend);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "/entry"}, got_q.pop_front(), exp_q.pop_front());
    end
    check({tag, "/entry_count"}, got_q.size(), exp_q.size());
  endtask

  // One keypad action: set ready, optionally hold a key for `hold` cycles, release, settle, check.
  task automatic action(input string tag, input bit do_press, input logic [3:0] code,
                        input int unsigned hold, input bit rdy);
    @(posedge clk);
    #1;
    entry_ready = rdy;
    if (m_wait && rdy) begin
      exp_q.push_back(m_pend);
      model_clear();
      m_wait = 0;
    end
    if (do_press && hold > 0) begin
      key_pressed = 1'b1;
      key_code    = code;
      repeat (hold) @(posedge clk);
      #1;
    end
    key_pressed = 1'b0;
    key_code    = 4'($urandom_range(15, 0));
    if (do_press && hold >= Deb) model_press(code, rdy);
    repeat (RelCycles) @(posedge clk);
    @(negedge clk);
    compare_state(tag);
  endtask

  task automatic key(input string tag, input logic [3:0] code, input bit rdy);
    action(tag, 1'b1, code, Deb + 2, rdy);
  endtask

  initial begin
    rst_n       = 1'b0;
    key_pressed = 1'b0;
    key_code    = 4'h0;
    entry_ready = 1'b1;
    model_clear();
    m_wait = 0;
    m_pend = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/display", display_value, 0);
    check("reset/count", digit_count, 0);
    check("reset/valid", entry_valid, 0);
    check("reset/entry_value", entry_value, 0);
    check("reset/overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic entry with immediate acceptance
    key("e123_1", 4'h1, 1'b1);
    key("e123_2", 4'h2, 1'b1);
    key("e123_3", 4'h3, 1'b1);
    check("e123/display_pre", display_value, 16'h0123);
    key("e123_enter", 4'hF, 1'b1);
    check("e123/pulse_len", last_run, 1);

    // Short glitch is filtered, exactly Deb cycles is accepted
    action("glitch5", 1'b1, 4'h5, 5, 1'b1);
    action("exact8", 1'b1, 4'h5, Deb, 1'b1);
    key("clr0", 4'hE, 1'b1);

    // Overflow and clear
    key("ovf_9", 4'h9, 1'b1);
    key("ovf_8", 4'h8, 1'b1);
    key("ovf_7", 4'h7, 1'b1);
    key("ovf_6", 4'h6, 1'b1);
    key("ovf_5", 4'h5, 1'b1);
    check("ovf/display", display_value, 16'h9876);
    check("ovf/flag", overflow, 1);
    key("ovf_clr", 4'hE, 1'b1);

    // Stalled handshake drops presses and holds the entry
    key("wait_1", 4'h1, 1'b1);
    key("wait_2", 4'h2, 1'b1);
    key("wait_enter", 4'hF, 1'b0);
    key("wait_4", 4'h4, 1'b0);
    check("wait/value", entry_value, 16'h0012);
    action("wait_idle", 1'b0, 4'h0, 0, 1'b0);
    action("wait_ack", 1'b0, 4'h0, 0, 1'b1);
    check("wait/count_after", digit_count, 0);

    // Hex key followed by enter
    key("hex_a", 4'hA, 1'b1);
    key("hex_enter", 4'hF, 1'b1);

    // Reset mid-entry abandons it
    key("rst_1", 4'h3, 1'b1);
    key("rst_2", 4'h4, 1'b1);
    key("rst_3", 4'h5, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst/display", display_value, 0);
    check("midrst/count", digit_count, 0);
    check("midrst/valid", entry_valid, 0);
    check("midrst/entry_value", entry_value, 0);
    check("midrst/overflow", overflow, 0);
    model_clear();
    m_wait = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      logic [3:0]  c;
      r = $urandom_range(99, 0);
      if (r < 60)      c = 4'($urandom_range(9, 0));
      else if (r < 70) c = 4'($urandom_range(13, 10));
      else if (r < 80) c = 4'hE;
      else             c = 4'hF;
      action($sformatf("rand%0d", i), 1'b1, c, $urandom_range(Deb + 6, Deb - 4),
             $urandom_range(3, 0) != 0);
    end

    check("hold_stable", unstable, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
